mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 70 +++++++
 rtl/mc_decode.sv | 33 +++
 rtl/mc_ctrl.sv | 149 ++++++++++++++
 tb/tb_mc_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// opcode/funct values, ALU operations, mux select codes and the decoded
// instruction class.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERR    = 3'd7
  } state_e;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // ALU operations
  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_OR   = 2'd2;
  localparam logic [1:0] ALU_LUI  = 2'd3;

  // Register-file destination select
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // Register-file write-data select
  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MEM   = 2'd1;
  localparam logic [1:0] WD_PC    = 2'd2;

  // Next-PC select
  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JAL  = 2'd2;
  localparam logic [1:0] NPC_JR   = 2'd3;

  // One-hot instruction class; all-zero means the encoding is illegal
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic nop;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
  } cls_t;

  function automatic logic cls_legal(input cls_t c);
    return |c;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier producing a one-hot instruction class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls
);

  // Map the instruction fields onto exactly one class bit (or none if illegal)
  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          FN_NOP:  cls.nop  = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle controller: state register, retired-instruction counter, sticky
// illegal flag and the per-state datapath strobe/select decode.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_busy,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        mem_we,
  output logic        mem_req,
  output logic [1:0]  regdst_sel,
  output logic [1:0]  wd_sel,
  output logic [1:0]  npc_sel,
  output logic        alusrc_b,
  output logic        ext_op,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        retire,
  output logic [31:0] icount,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] icount_q, icount_d;
  logic        illegal_q, illegal_d;
  cls_t        cls;

  // The IR holds the instruction from DECODE onward, so the class stays valid
  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  // State, counter and sticky flag; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      icount_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      icount_q  <= icount_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state selection following each instruction class's path
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (!cls_legal(cls))   state_d = ST_ERR;
        else if (cls.nop)      state_d = ST_FETCH;
        else if (cls.jal)      state_d = ST_WB;
        else                   state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cls.beq || cls.jr)     state_d = ST_FETCH;
        else if (cls.lw || cls.sw) state_d = ST_MEM;
        else                       state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_busy)    state_d = ST_MEM;
        else if (cls.lw) state_d = ST_WB;
        else             state_d = ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_ERR:  state_d = ST_ERR;
      // Unused encodings are treated as a fault and parked in ERR
      default: state_d = ST_ERR;
    endcase
  end

  // Retire marks the last cycle of an instruction; the counter wraps naturally
  always_comb begin
    retire    = (state_d == ST_FETCH);
    icount_d  = retire ? icount_q + 32'd1 : icount_q;
    illegal_d = illegal_q | ((state_q == ST_DECODE) && !cls_legal(cls));
  end

  // Datapath strobes and selects, decoded from state and instruction class
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    mem_req    = 1'b0;
    regdst_sel = REGDST_RT;
    wd_sel     = WD_ALU;
    npc_sel    = NPC_PC4;
    alusrc_b   = 1'b0;
    ext_op     = 1'b0;
    alu_op     = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        npc_sel = NPC_PC4;
      end
      ST_EXEC: begin
        if (cls.subu || cls.beq) alu_op = ALU_SUB;
        else if (cls.ori)        alu_op = ALU_OR;
        else if (cls.lui)        alu_op = ALU_LUI;
        else                     alu_op = ALU_ADD;
        alusrc_b = cls.ori | cls.lui | cls.lw | cls.sw;
        ext_op   = cls.lw | cls.sw | cls.beq;
        if (cls.beq && zero) begin
          pc_we   = 1'b1;
          npc_sel = NPC_BR;
        end
        if (cls.jr) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JR;
        end
      end
      ST_MEM: begin
        mem_req = cls.lw | cls.sw;
        mem_we  = cls.sw;
      end
      ST_WB: begin
        reg_we = 1'b1;
        if (cls.addu || cls.subu) regdst_sel = REGDST_RD;
        else if (cls.jal)         regdst_sel = REGDST_RA;
        else                      regdst_sel = REGDST_RT;
        if (cls.lw)       wd_sel = WD_MEM;
        else if (cls.jal) wd_sel = WD_PC;
        else              wd_sel = WD_ALU;
        if (cls.jal) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JAL;
        end
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign icount  = icount_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios followed by random
// instruction streams, checked cycle by cycle against a path/rule model.
module tb_mc_ctrl;

  logic        clk, reset;
  logic [5:0]  opcode, funct;
  logic        zero, mem_busy;
  logic        pc_we, ir_we, reg_we, mem_we, mem_req;
  logic [1:0]  regdst_sel, wd_sel, npc_sel, alu_op;
  logic        alusrc_b, ext_op;
  logic [2:0]  state;
  logic        retire, illegal;
  logic [31:0] icount;
  logic [14:0] outs;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_ic;
  bit          model_ill;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_NOP = 3, K_ORI = 4,
                 K_LUI = 5, K_LW = 6, K_SW = 7, K_BEQ = 8, K_JAL = 9, K_ILL = 10;

  mc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_busy   (mem_busy),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .reg_we     (reg_we),
    .mem_we     (mem_we),
    .mem_req    (mem_req),
    .regdst_sel (regdst_sel),
    .wd_sel     (wd_sel),
    .npc_sel    (npc_sel),
    .alusrc_b   (alusrc_b),
    .ext_op     (ext_op),
    .alu_op     (alu_op),
    .state      (state),
    .retire     (retire),
    .icount     (icount),
    .illegal    (illegal)
  );

  assign outs = {pc_we, ir_we, reg_we, mem_we, mem_req, regdst_sel, wd_sel,
                 npc_sel, alusrc_b, ext_op, alu_op};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] op_of(input int k);
    case (k)
      K_ORI:   return 6'h0D;
      K_LUI:   return 6'h0F;
      K_LW:    return 6'h23;
      K_SW:    return 6'h2B;
      K_BEQ:   return 6'h04;
      K_JAL:   return 6'h03;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] fn_of(input int k);
    case (k)
      K_ADDU:  return 6'h21;
      K_SUBU:  return 6'h23;
      K_JR:    return 6'h08;
      default: return 6'h00;
    endcase
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    for (int k = 0; k < K_ILL; k++)
      if (op == op_of(k) && (op != 6'h00 || fn == fn_of(k))) return k;
    return K_ILL;
  endfunction

  // Expected strobes/selects for instruction kind k while in state st
  function automatic logic [14:0] exp_out(input int k, input int st, input bit z);
    bit pcw = 0, irw = 0, rw = 0, mw = 0, mr = 0, asb = 0, ext = 0;
    logic [1:0] rd = 0, wd = 0, npc = 0, alu = 0;
    case (st)
      0: begin pcw = 1; irw = 1; end
      2: begin
        if (k == K_SUBU || k == K_BEQ) alu = 1;
        else if (k == K_ORI)           alu = 2;
        else if (k == K_LUI)           alu = 3;
        asb = (k inside {K_ORI, K_LUI, K_LW, K_SW});
        ext = (k inside {K_LW, K_SW, K_BEQ});
        if (k == K_BEQ && z) begin pcw = 1; npc = 1; end
        if (k == K_JR)       begin pcw = 1; npc = 3; end
      end
      3: begin mr = 1; mw = (k == K_SW); end
      4: begin
        rw = 1;
        if (k == K_ADDU || k == K_SUBU) rd = 1;
        else if (k == K_JAL)            rd = 2;
        if (k == K_LW)       wd = 1;
        else if (k == K_JAL) wd = 2;
        if (k == K_JAL) begin pcw = 1; npc = 2; end
      end
      default: ;
    endcase
    return {pcw, irw, rw, mw, mr, rd, wd, npc, asb, ext, alu};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Runs one instruction starting at a negedge; returns at a negedge.
  // zmode<0 randomises zero each cycle; abort_at>=0 asserts reset at that step.
  task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int nbusy, input int abort_at);
    int path[$];
    int mem_left = nbusy;
    path.push_back(0);
    path.push_back(1);
    case (k)
      K_ADDU, K_SUBU, K_ORI, K_LUI: begin path.push_back(2); path.push_back(4); end
      K_LW: begin
        path.push_back(2);
        for (int j = 0; j <= nbusy; j++) path.push_back(3);
        path.push_back(4);
      end
      K_SW: begin
        path.push_back(2);
        for (int j = 0; j <= nbusy; j++) path.push_back(3);
      end
      K_BEQ, K_JR: path.push_back(2);
      K_JAL:       path.push_back(4);
      K_ILL:       for (int j = 0; j < 10; j++) path.push_back(7);
      default: ;
    endcase
    opcode = op;
    funct  = fn;
    for (int i = 0; i < path.size(); i++) begin
      bit z;
      bit last;
      last = (i == path.size() - 1);
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
      zero = z;
      if (path[i] == 3) begin
        mem_busy = (mem_left > 0);
        if (mem_left > 0) mem_left--;
      end else begin
        mem_busy = 1'($urandom_range(0, 1));
      end
      #1;
      chk("state", 32'(state), path[i]);
      chk("strobes", 32'(outs), 32'(exp_out(k, path[i], z)));
      chk("retire", 32'(retire), 32'(last && k != K_ILL));
      chk("icount", icount, model_ic);
      chk("illegal", 32'(illegal), 32'(model_ill));
      if (i == abort_at) begin
        #1 reset = 1'b0;
        #1;
        model_ic  = 0;
        model_ill = 0;
        chk("rst_state", 32'(state), 0);
        chk("rst_icount", icount, model_ic);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_retire", 32'(retire), 0);
        @(negedge clk);
        return;
      end
      if (path[i] == 1 && k == K_ILL) model_ill = 1;
      if (last && k != K_ILL) model_ic++;
      @(negedge clk);
    end
  endtask

  // Pulse reset starting at a negedge; returns at a negedge with reset released
  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    model_ic  = 0;
    model_ill = 0;
    chk("rst_state", 32'(state), 0);
    chk("rst_icount", icount, model_ic);
    chk("rst_illegal", 32'(illegal), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] ir;
    logic [5:0]  op, fn;
    int          k;
    reset = 1'b0;
    opcode = '0;
    funct = '0;
    zero = 1'b0;
    mem_busy = 1'b0;
    model_ic = 0;
    model_ill = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(state), 0);
    chk("reset_icount", icount, 0);
    chk("reset_illegal", 32'(illegal), 0);
    @(negedge clk);
    reset = 1'b1;

    // addu $2,$4,$5
    ir = 32'h0085_1021;
    run_instr(K_ADDU, ir[31:26], ir[5:0], -1, 0, -1);
    chk("addu_icount", icount, 1);

    // lw stalled three cycles in MEM
    run_instr(K_LW, 6'h23, 6'h15, -1, 3, -1);
    // beq taken then not taken
    run_instr(K_BEQ, 6'h04, 6'h3A, 1, 0, -1);
    run_instr(K_BEQ, 6'h04, 6'h3A, 0, 0, -1);
    // jal
    run_instr(K_JAL, 6'h03, 6'h07, -1, 0, -1);
    // illegal opcode 0x3F, then reset recovers
    run_instr(K_ILL, 6'h3F, 6'h00, -1, 0, -1);
    reset_pulse();

    // icount wrap via a preloaded counter and one nop
    force dut.icount_q = 32'hFFFF_FFFF;
    model_ic = 32'hFFFF_FFFF;
    opcode = 6'h00;
    funct  = 6'h00;
    #1;
    chk("wrap_pre", icount, model_ic);
    chk("wrap_state_f", 32'(state), 0);
    @(negedge clk);
    release dut.icount_q;
    #1;
    chk("wrap_state_d", 32'(state), 1);
    chk("wrap_retire", 32'(retire), 1);
    chk("wrap_hold", icount, model_ic);
    @(negedge clk);
    model_ic = model_ic + 1;
    #1;
    chk("wrap_icount", icount, model_ic);
    chk("wrap_state_next", 32'(state), 0);

    // lw abandoned by reset during a busy MEM cycle
    run_instr(K_LW, 6'h23, 6'h01, -1, 5, 4);
    reset = 1'b1;

    // random instruction stream
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, K_ILL);
      if (k == K_ILL) begin
        do begin
          op = 6'($urandom);
          fn = 6'($urandom);
        end while (classify(op, fn) != K_ILL);
      end else begin
        op = op_of(k);
        fn = (op == 6'h00) ? fn_of(k) : 6'($urandom);
      end
      run_instr(k, op, fn, -1, $urandom_range(0, 3), -1);
      if (k == K_ILL) reset_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
